// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - IF/MEM arbiter and byte-serial sequencer for a unified 8-bit RAM port
// Optional feature macro: MEM_SEQ_IO_HOLD_EN adds io_buffer_full_i, which holds stores to addr[17:16] == 2'b11.
module mem_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
`ifdef MEM_SEQ_IO_HOLD_EN
  input  logic              io_buffer_full_i,
`endif
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_sext_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o
);

  if (RAM_LAT != 1) begin : g_lat_check
    $error("mem_sequencer: only RAM_LAT == 1 is supported");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [2:0]        r_k;
  logic [2:0]        r_n;
  logic              r_is_if;
  logic              r_sext;
  logic [ADDR_W-1:0] r_base;
  logic [3:0][7:0]   r_wdata;
  logic [3:0][7:0]   r_bytes;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_dout;
  logic              r_if_done;
  logic              r_mem_done;
  logic [31:0]       r_if_inst;
  logic [31:0]       r_mem_rdata;

  logic [2:0]        w_size_n;
  logic [2:0]        w_k_inc;
  logic [1:0]        w_lane;
  logic [ADDR_W-1:0] w_next_addr;
  logic [3:0][7:0]   w_word;
  logic [31:0]       w_load;
  logic              w_hold;
  logic              w_issue;

  // Byte count for the requested MEM access; size 11 behaves as a word.
  always_comb begin
    w_size_n = 3'd4;
    case (mem_size_i)
      2'b00:   w_size_n = 3'd1;
      2'b01:   w_size_n = 3'd2;
      default: w_size_n = 3'd4;
    endcase
  end

  assign w_k_inc     = r_k + 3'd1;
  assign w_lane      = r_k[1:0] - 2'd1;
  assign w_next_addr = r_base + ADDR_W'(w_k_inc);

`ifdef MEM_SEQ_IO_HOLD_EN
  assign w_hold = io_buffer_full_i && (r_ram_addr[17:16] == 2'b11);
`else
  assign w_hold = 1'b0;
`endif

  // A store byte is issued only in WRITE and only when the IO buffer is not holding it.
  assign w_issue = (r_state == S_WRITE) && !w_hold;

  // Captured bytes with the byte arriving this cycle merged into its lane.
  always_comb begin
    w_word         = r_bytes;
    w_word[w_lane] = ram_din_i;
  end

  // Zero/sign extension of the assembled load result.
  always_comb begin
    w_load = w_word;
    case (r_n)
      3'd1:    w_load = r_sext ? {{24{w_word[0][7]}}, w_word[0]} : {24'd0, w_word[0]};
      3'd2:    w_load = r_sext ? {{16{w_word[1][7]}}, w_word[1], w_word[0]}
                               : {16'd0, w_word[1], w_word[0]};
      default: w_load = w_word;
    endcase
  end

  // Sequencer FSM: arbitrate in IDLE, step bytes in READ/WRITE, pulse done in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= 3'd0;
      r_n         <= 3'd0;
      r_is_if     <= 1'b0;
      r_sext      <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_bytes     <= '0;
      r_ram_addr  <= '0;
      r_ram_dout  <= 8'd0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_inst   <= 32'd0;
      r_mem_rdata <= 32'd0;
    end else if (rdy) begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_k <= 3'd0;
          if (mem_req_i) begin
            r_is_if    <= 1'b0;
            r_base     <= mem_addr_i;
            r_ram_addr <= mem_addr_i;
            r_n        <= w_size_n;
            r_sext     <= mem_sext_i;
            r_wdata    <= mem_wdata_i;
            r_ram_dout <= mem_wdata_i[7:0];
            r_state    <= mem_we_i ? S_WRITE : S_READ;
          end else if (if_req_i) begin
            r_is_if    <= 1'b1;
            r_base     <= if_addr_i;
            r_ram_addr <= if_addr_i;
            r_n        <= 3'd4;
            r_sext     <= 1'b0;
            r_state    <= S_READ;
          end
        end
        S_READ: begin
          if (r_is_if && !if_req_i) begin
            r_state <= S_IDLE;
            r_k     <= 3'd0;
          end else begin
            // r_k counts address cycles already issued; data trails address by one cycle.
            if (r_k != 3'd0) begin
              r_bytes[w_lane] <= ram_din_i;
            end
            if (r_k == r_n) begin
              r_state <= S_DONE;
              r_k     <= 3'd0;
              if (r_is_if) begin
                r_if_done <= 1'b1;
                r_if_inst <= w_word;
              end else begin
                r_mem_done  <= 1'b1;
                r_mem_rdata <= w_load;
              end
            end else begin
              r_k <= w_k_inc;
              if (w_k_inc < r_n) begin
                r_ram_addr <= w_next_addr;
              end
            end
          end
        end
        S_WRITE: begin
          if (w_issue) begin
            if (w_k_inc == r_n) begin
              r_state    <= S_DONE;
              r_k        <= 3'd0;
              r_mem_done <= 1'b1;
            end else begin
              r_k        <= w_k_inc;
              r_ram_addr <= w_next_addr;
              r_ram_dout <= r_wdata[w_k_inc[1:0]];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign if_done_o   = r_if_done;
  assign if_inst_o   = r_if_inst;
  assign mem_done_o  = r_mem_done;
  assign mem_rdata_o = r_mem_rdata;
  assign ram_addr_o  = r_ram_addr;
  assign ram_dout_o  = r_ram_dout;
  assign ram_wr_o    = w_issue && rdy;

endmodule
